// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/sub/and/xor ALU between two requesters.
// Response carries the Y86 condition flags and the owning requester id.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; the granted valid requester sees ready
// EXEC  | ALU runs on the captured operands; result/flags get registered
// RESP  | response held until the consumer takes it with rsp_ready
module alu_share_arbiter #(
   parameter int W   = 64,
   parameter int OPW = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_result,
   output logic           rsp_zf,
   output logic           rsp_sf,
   output logic           rsp_of
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB = OPW'(1);
   localparam logic [OPW-1:0] OP_AND = OPW'(2);

   state_t         state;
   logic           ptr;
   logic           id_q;
   logic [OPW-1:0] op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;

   logic           any_valid;
   logic           grant_id;

   // Pointer only breaks ties; a lone valid requester always wins.
   assign any_valid  = req0_valid | req1_valid;
   assign grant_id   = (req0_valid & req1_valid) ? ptr : req1_valid;
   assign req0_ready = (state == IDLE) & ~reset & req0_valid & ~grant_id;
   assign req1_ready = (state == IDLE) & ~reset & req1_valid & grant_id;

   logic           is_sub;
   logic [W-1:0]   b_eff;
   logic [W-1:0]   sum;
   logic [W-1:0]   alu_res;
   logic           alu_of;

   // Subtraction reuses the adder as a + ~b + 1, so one overflow rule covers both.
   always_comb begin
      is_sub  = (op_q == OP_SUB);
      b_eff   = is_sub ? ~b_q : b_q;
      sum     = a_q + b_eff + {{(W-1){1'b0}}, is_sub};
      alu_res = sum;
      alu_of  = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            alu_res = sum;
            alu_of  = (a_q[W-1] == b_eff[W-1]) && (sum[W-1] != a_q[W-1]);
         end
         OP_AND:  alu_res = a_q & b_q;
         default: alu_res = a_q ^ b_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         id_q       <= 1'b0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zf     <= 1'b0;
         rsp_sf     <= 1'b0;
         rsp_of     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  op_q  <= grant_id ? req1_op : req0_op;
                  a_q   <= grant_id ? req1_a  : req0_a;
                  b_q   <= grant_id ? req1_b  : req0_b;
                  id_q  <= grant_id;
                  ptr   <= ~grant_id;
                  state <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_res;
               rsp_zf     <= (alu_res == '0);
               rsp_sf     <= alu_res[W-1];
               rsp_of     <= alu_of;
               rsp_id     <= id_q;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios followed by random traffic,
// checked by a negedge monitor against a transaction-level arbitration/ALU model.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [63:0] rsp_result;
   logic        rsp_zf, rsp_sf, rsp_of;

   always #5 clk = ~clk;

   alu_share_arbiter #(.W(64), .OPW(2)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        id;
      logic [63:0] res;
      logic        zf, sf, of;
   } rsp_t;

   rsp_t sb[$];

   // Reference ALU: signed 65-bit arithmetic, overflow when the true result leaves the 64-bit range.
   function automatic rsp_t model(input logic id, input logic [1:0] op,
                                  input logic [63:0] a, input logic [63:0] b);
      rsp_t r;
      logic signed [64:0] sa, sbv, wide;
      sa   = $signed({a[63], a});
      sbv  = $signed({b[63], b});
      wide = '0;
      r.id = id;
      r.of = 1'b0;
      case (op)
         2'd0: begin wide = sa + sbv; r.res = wide[63:0]; r.of = (wide[64] != wide[63]); end
         2'd1: begin wide = sa - sbv; r.res = wide[63:0]; r.of = (wide[64] != wide[63]); end
         2'd2: r.res = a & b;
         default: r.res = a ^ b;
      endcase
      r.zf = (r.res == 64'd0);
      r.sf = r.res[63];
      return r;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   int   m_state = 0;   // 0 free, 1 waiting for result, 2 response outstanding
   bit   m_ptr   = 1'b0;
   int   lat;
   bit   held_ok;
   bit   post_rst;
   rsp_t held;

   always @(negedge clk) begin
      logic g, er0, er1;
      if (reset) begin
         chk("ready_in_reset", {req0_ready, req1_ready}, 2'b00);
         sb.delete();
         m_state  = 0;
         m_ptr    = 1'b0;
         post_rst = 1'b1;
      end else begin
         if (post_rst) begin
            chk("reset_rsp_valid", rsp_valid, 1'b0);
            chk("reset_rsp_result", rsp_result, 64'd0);
            chk("reset_rsp_id_flags", {rsp_id, rsp_zf, rsp_sf, rsp_of}, 4'b0);
            post_rst = 1'b0;
         end
         if (m_state == 0) begin
            chk("idle_rsp_valid", rsp_valid, 1'b0);
            g   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            er0 = req0_valid && !g;
            er1 = req1_valid && g;
            chk("grant_ready", {req0_ready, req1_ready}, {er0, er1});
            if (req0_valid || req1_valid) begin
               if (g) sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
               else   sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
               m_ptr   = !g;
               m_state = 1;
               lat     = 0;
            end
         end else begin
            chk("busy_ready", {req0_ready, req1_ready}, 2'b00);
            if (m_state == 1) begin
               lat++;
               if (lat == 1) chk("exec_rsp_valid", rsp_valid, 1'b0);
               else begin
                  m_state = 2;
                  held_ok = 1'b0;
               end
            end
            if (m_state == 2) begin
               chk("resp_valid", rsp_valid, 1'b1);
               if (!held_ok) begin
                  chk("sb_has_entry", sb.size() != 0, 1'b1);
                  if (sb.size() != 0) begin
                     held    = sb.pop_front();
                     held_ok = 1'b1;
                  end
               end
               if (held_ok) begin
                  chk("rsp_id", rsp_id, held.id);
                  chk("rsp_result", rsp_result, held.res);
                  chk("rsp_flags_zso", {rsp_zf, rsp_sf, rsp_of}, {held.zf, held.sf, held.of});
               end
               if (rsp_ready) m_state = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   bit s0, s1;
   bit auto0 = 0, auto1 = 0, auto_rsp = 0;
   int pv = 50, prsp = 70;

   function automatic logic [63:0] rand_val();
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return 64'h8000_0000_0000_0000;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return '1;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   // One clock: sample readies, then after the edge retire handshaken requests and drive new ones.
   task automatic tick();
      @(negedge clk);
      s0 = req0_ready;
      s1 = req1_ready;
      @(posedge clk);
      #1;
      if (s0) req0_valid = 1'b0;
      if (s1) req1_valid = 1'b0;
      if (auto0) begin
         if (!req0_valid && $urandom_range(0, 99) < pv) begin
            req0_valid = 1'b1; req0_op = 2'($urandom_range(0, 3));
            req0_a = rand_val(); req0_b = rand_val();
         end else if (req0_valid && $urandom_range(0, 99) < 5) req0_valid = 1'b0;
      end
      if (auto1) begin
         if (!req1_valid && $urandom_range(0, 99) < pv) begin
            req1_valid = 1'b1; req1_op = 2'($urandom_range(0, 3));
            req1_a = rand_val(); req1_b = rand_val();
         end else if (req1_valid && $urandom_range(0, 99) < 5) req1_valid = 1'b0;
      end
      if (auto_rsp) rsp_ready = ($urandom_range(0, 99) < prsp);
   endtask

   task automatic send(input bit k, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      int n = 0;
      if (k) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
      else   begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
      while ((k ? req1_valid : req0_valid) && n < 40) begin
         tick();
         n++;
      end
      chk("send_granted", k ? req1_valid : req0_valid, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Grant req0, then hit reset while the op is in EXEC.
   task automatic reset_in_exec();
      send(1'b0, 2'd0, 64'h1234, 64'h4321);
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rsp_ready = 1'b1;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      idle(3);
      reset = 1'b0;
      tick();

      send(1'b0, 2'd0, 64'd5, 64'd7);
      idle(4);
      send(1'b1, 2'd1, 64'h8000_0000_0000_0000, 64'd1);
      idle(4);
      send(1'b1, 2'd1, 64'd3, 64'd3);
      idle(4);
      send(1'b0, 2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0);
      idle(4);
      send(1'b1, 2'd3, 64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF);
      idle(4);

      // continuous contention
      pv = 100; auto0 = 1; auto1 = 1;
      req0_valid = 1; req0_op = 0; req0_a = 64'd100; req0_b = 64'd1;
      req1_valid = 1; req1_op = 1; req1_a = 64'd100; req1_b = 64'd1;
      idle(16);
      auto0 = 0; auto1 = 0;
      idle(20);

      // back-pressure with both requesters waiting
      rsp_ready = 1'b0;
      send(1'b0, 2'd1, 64'd0, 64'd1);
      req0_valid = 1; req0_op = 3; req0_a = 64'hAA; req0_b = 64'h55;
      req1_valid = 1; req1_op = 0; req1_a = '1;     req1_b = 64'd1;
      idle(7);
      rsp_ready = 1'b1;
      idle(12);

      // reset in EXEC: pointer must return to 0, so req0 wins the tie
      reset_in_exec();
      req0_valid = 1; req0_op = 0; req0_a = 64'd9; req0_b = 64'd9;
      req1_valid = 1; req1_op = 0; req1_a = 64'd1; req1_b = 64'd1;
      idle(12);
      reset_in_exec();
      send(1'b1, 2'd0, 64'd40, 64'd2);
      idle(4);

      // random traffic
      pv = 50; auto0 = 1; auto1 = 1; auto_rsp = 1;
      idle(3000);
      auto0 = 0; auto1 = 0; auto_rsp = 0; rsp_ready = 1'b1;
      idle(30);
      chk("sb_drained", sb.size(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 64-bit ALU (add/sub/and/xor) between two requesters.
- Requester 0 is the execute-stage operation path. Requester 1 is the address/condition helper path.
- Round-robin grant, registered operands, one-cycle compute, then a response held with valid/ready handshake.
- Produces the result plus Y86 condition flags (ZF, SF, OF), tagged with the requester ID.

Parameters:
- W, 64, datapath width in bits.
- OPW, 2, ALU op-code width; codes follow Y86 ifun: 0=add, 1=sub, 2=and, 3=xor.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  OPW  requester 0 op code.
- req0_a  input  W  requester 0 operand A.
- req0_b  input  W  requester 0 operand B.
- req1_valid  input  1  requester 1 has an operation pending.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_op  input  OPW  requester 1 op code.
- req1_a  input  W  requester 1 operand A.
- req1_b  input  W  requester 1 operand B.
- rsp_valid  output  1  response registers hold a valid result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that owns the response (0 or 1).
- rsp_result  output  W  ALU result.
- rsp_zf  output  1  zero flag.
- rsp_sf  output  1  sign flag.
- rsp_of  output  1  signed-overflow flag.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (synchronous, active-high):
  - state goes to IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zf=rsp_sf=rsp_of=0.
  - Operand registers clear to 0.
  - Priority pointer set to 0 (requester 0 favoured).
  - Any in-flight op is discarded and produces no response.
  - reset overrides every other input in the same cycle.
- IDLE:
  - reqN_ready is combinational. It is 1 only in IDLE, for the single granted requester with valid=1.
  - Only one requester is granted. If only one requester is valid, it wins. If both are valid, the requester named by the priority pointer wins.
  - On handshake (valid & ready): capture op/a/b and the grant ID into registers, flip the pointer to the non-granted requester, go to EXEC.
  - With no valid request, stay in IDLE; both readies are 0.
- EXEC:
  - The shared ALU operates on the registered operands.
  - Result and flags are registered into the rsp_* outputs; rsp_valid becomes 1; go to RESP.
  - Both readies are 0.
- RESP:
  - rsp_* outputs hold stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid=0 next cycle and state goes to IDLE. rsp_result, rsp_id and flags keep their last values.
  - Both readies are 0 in RESP; no new request is accepted in the release cycle.
- Latency: handshake at edge T, rsp_valid=1 after edge T+1. Minimum issue interval is 3 cycles.
- Arithmetic (all results mod 2^W, two's complement):
  - add: a+b, carry-out discarded.
  - sub: a-b, computed as a + ~b + 1.
  - and: a&b.
  - xor: a^b.
- Flags:
  - ZF = (result==0).
  - SF = result[W-1].
  - OF for add = (a[W-1]==b[W-1]) && (result[W-1]!=a[W-1]).
  - OF for sub = (a[W-1]!=b[W-1]) && (result[W-1]!=a[W-1]).
  - OF for and/xor = 0.
- Requester-side rules:
  - A requester must keep valid and operands stable until it sees ready.
  - Dropping valid before the grant is legal; no operation issues.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1…
- Illegal op codes cannot occur because OPW=2 covers all four encodings.

Test Plan:
1. Basic add: after reset, req0 op=0, a=5, b=7 → req0_ready=1 in the request cycle; rsp_valid two edges later with result=12, id=0, ZF=SF=OF=0.
2. Sub with signed overflow: req1 op=1, a=0x8000000000000000, b=1 → result=0x7FFFFFFFFFFFFFFF, SF=0, OF=1, ZF=0, id=1.
   - Also a=3, b=3 → result=0, ZF=1.
3. Contention fairness: both valid continuously for 4 operations with rsp_ready=1 → grant order 0,1,0,1; rsp_id sequence matches; no two readies high in the same cycle.
4. Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid → outputs stable; req0_ready=req1_ready=0 throughout; the next grant comes only after the rsp_ready pulse and return to IDLE.
5. Logic ops: and with a=0xF0F0…F0, b=0x0FF0…0FF0 → result=0x00F0…00F0, OF=0. xor with a=b=0xDEADBEEFDEADBEEF → result=0, ZF=1, OF=0.
6. Reset mid-operation: assert reset in the EXEC cycle → next cycle state IDLE, rsp_valid=0, rsp_result=0. The dropped op never appears, and a following req1 request is granted first (pointer back to 0 with only req1 valid).
